// File: rtl/ntt_result_uart_writer.sv
// ntt_result_uart_writer
// Return path of the NTT accelerator. Captures one block of RADIX result words
// and sends them on an 8N1 UART line, word 0 first. Each word goes out
// least-significant byte first, which is the same byte order the host used on
// the input path.
//
// Ports:
//   clk_i           clock, all logic on the rising edge
//   rst_n_i         synchronous active-low reset
//   result_valid_i  result_data_i holds a valid result this cycle
//   result_data_i   NTT result word (W bits)
//   ready_o         high while capturing results
//   tx_o            UART serial line, idle high
//   busy_o          high while the block is being sent
//   done_o          one-cycle pulse after the last stop bit of the block
//   drop_o          one-cycle pulse for a result offered while ready_o was low
module ntt_result_uart_writer #(
    parameter int unsigned W            = 32,
    parameter int unsigned RADIX        = 16,
    parameter int unsigned CLKS_PER_BIT = 87
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic         result_valid_i,
    input  logic [W-1:0] result_data_i,
    output logic         ready_o,
    output logic         tx_o,
    output logic         busy_o,
    output logic         done_o,
    output logic         drop_o
);

    localparam int unsigned BYTES_PER_WORD = W / 8;
    localparam int unsigned CW = $clog2(RADIX) + 1;
    localparam int unsigned AW = (RADIX > 1) ? $clog2(RADIX) : 1;
    localparam int unsigned BW = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
    localparam int unsigned DW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    typedef enum logic [2:0] {
        S_CAPTURE,
        S_START,
        S_DATA,
        S_STOP,
        S_FINISH
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  count_q, count_d;
    logic [AW-1:0]  word_q,  word_d;
    logic [BW-1:0]  byte_q,  byte_d;
    logic [2:0]     bit_q,   bit_d;
    logic [DW-1:0]  baud_q,  baud_d;
    logic [7:0]     tx_byte_q;
    logic [W-1:0]   buffer_q [RADIX];

    logic           capture;
    logic           byte_load;
    logic           baud_end;
    logic           last_byte_of_word;
    logic           tx_d, ready_d, busy_d, done_d, drop_d;

    // Next-state and next-output logic; outputs are decoded from the next
    // state so the registered outputs line up with the registered state.
    always_comb begin
        state_d           = state_q;
        count_d           = count_q;
        word_d            = word_q;
        byte_d            = byte_q;
        bit_d             = bit_q;
        baud_d            = baud_q;
        capture           = 1'b0;
        byte_load         = 1'b0;
        baud_end          = (baud_q == DW'(CLKS_PER_BIT - 1));
        last_byte_of_word = (byte_q == BW'(BYTES_PER_WORD - 1));
        tx_d              = 1'b1;
        ready_d           = 1'b0;
        busy_d            = 1'b0;
        done_d            = 1'b0;
        drop_d            = result_valid_i && (state_q != S_CAPTURE);

        case (state_q)
            S_CAPTURE: begin
                if (result_valid_i) begin
                    capture = 1'b1;
                    count_d = count_q + CW'(1);
                    if (count_q == CW'(RADIX - 1)) begin
                        state_d   = S_START;
                        word_d    = '0;
                        byte_d    = '0;
                        bit_d     = '0;
                        baud_d    = '0;
                        byte_load = 1'b1;
                    end
                end
            end
            S_START: begin
                if (baud_end) begin
                    baud_d  = '0;
                    bit_d   = '0;
                    state_d = S_DATA;
                end else begin
                    baud_d = baud_q + DW'(1);
                end
            end
            S_DATA: begin
                if (baud_end) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q + DW'(1);
                end
            end
            S_STOP: begin
                if (baud_end) begin
                    baud_d = '0;
                    if (last_byte_of_word && (word_q == AW'(RADIX - 1))) begin
                        state_d = S_FINISH;
                    end else begin
                        // Next byte starts immediately, no idle gap.
                        state_d   = S_START;
                        byte_load = 1'b1;
                        if (last_byte_of_word) begin
                            byte_d = '0;
                            word_d = word_q + AW'(1);
                        end else begin
                            byte_d = byte_q + BW'(1);
                        end
                    end
                end else begin
                    baud_d = baud_q + DW'(1);
                end
            end
            S_FINISH: begin
                count_d = '0;
                state_d = S_CAPTURE;
            end
            default: begin
                state_d = S_CAPTURE;
            end
        endcase

        case (state_d)
            S_CAPTURE: ready_d = 1'b1;
            S_START: begin
                busy_d = 1'b1;
                tx_d   = 1'b0;
            end
            S_DATA: begin
                // tx_byte_q was loaded on entry to the preceding start bit.
                busy_d = 1'b1;
                tx_d   = tx_byte_q[bit_d];
            end
            S_STOP:   busy_d = 1'b1;
            S_FINISH: done_d = 1'b1;
            default: ;
        endcase
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q <= S_CAPTURE;
            count_q <= '0;
            word_q  <= '0;
            byte_q  <= '0;
            bit_q   <= '0;
            baud_q  <= '0;
            tx_o    <= 1'b1;
            ready_o <= 1'b1;
            busy_o  <= 1'b0;
            done_o  <= 1'b0;
            drop_o  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            word_q  <= word_d;
            byte_q  <= byte_d;
            bit_q   <= bit_d;
            baud_q  <= baud_d;
            tx_o    <= tx_d;
            ready_o <= ready_d;
            busy_o  <= busy_d;
            done_o  <= done_d;
            drop_o  <= drop_d;
        end
    end

    // Result buffer and current transmit byte; contents need no reset since
    // they are always overwritten before being sent.
    always_ff @(posedge clk_i) begin
        if (capture) begin
            buffer_q[count_q[AW-1:0]] <= result_data_i;
        end
        if (byte_load) begin
            tx_byte_q <= buffer_q[word_d][8*int'(byte_d) +: 8];
        end
    end

endmodule

// File: tb/tb_ntt_result_uart_writer.sv
// tb_ntt_result_uart_writer
// Self-checking bench for ntt_result_uart_writer (W=32, RADIX=16,
// CLKS_PER_BIT=4). Expected line waveforms and byte streams come from a
// word-to-byte model; a bench receiver decodes tx_o at mid-bit.
module tb_ntt_result_uart_writer;

    localparam int unsigned W      = 32;
    localparam int unsigned RADIX  = 16;
    localparam int unsigned CPB    = 4;
    localparam int unsigned BPW    = W / 8;
    localparam int unsigned NBYTES = RADIX * BPW;
    localparam int unsigned FRAME  = 10 * CPB;
    localparam int unsigned SPAN   = NBYTES * FRAME;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         valid;
    logic [W-1:0] data;
    logic         ready_o, tx_o, busy_o, done_o, drop_o;

    int checks   = 0;
    int failures = 0;

    logic [W-1:0] words     [RADIX];
    logic [7:0]   exp_bytes [NBYTES];
    logic [7:0]   rx_bytes  [NBYTES];
    logic         line      [SPAN];

    ntt_result_uart_writer #(
        .W            (W),
        .RADIX        (RADIX),
        .CLKS_PER_BIT (CPB)
    ) dut (
        .clk_i          (clk),
        .rst_n_i        (rst_n),
        .result_valid_i (valid),
        .result_data_i  (data),
        .ready_o        (ready_o),
        .tx_o           (tx_o),
        .busy_o         (busy_o),
        .done_o         (done_o),
        .drop_o         (drop_o)
    );

    always #5 clk = ~clk;

    // Byte stream the host should see: words in order, LSB byte first.
    task automatic build_model();
        for (int j = 0; j < RADIX; j++)
            for (int k = 0; k < BPW; k++)
                exp_bytes[j*BPW + k] = 8'((words[j] >> (8*k)) & 32'hFF);
    endtask

    // Expected line level t cycles after the first start bit.
    function automatic logic exp_line(int t);
        int f, b;
        f = t / FRAME;
        b = (t / CPB) % 10;
        if (b == 0) return 1'b0;
        if (b == 9) return 1'b1;
        return exp_bytes[f][b-1];
    endfunction

    task automatic random_words();
        for (int i = 0; i < RADIX; i++) words[i] = $urandom;
    endtask

    // Drive the 16 words; inputs change on the falling edge.
    task automatic send_block(input int max_gap, input bit start_now);
        int bad;
        int gap;
        bad = 0;
        for (int i = 0; i < RADIX; i++) begin
            if (!(i == 0 && start_now)) begin
                gap = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
                repeat (gap) begin
                    @(negedge clk);
                    if (ready_o !== 1'b1 || tx_o !== 1'b1 || busy_o !== 1'b0) bad++;
                    valid = 1'b0;
                    data  = $urandom;
                end
                @(negedge clk);
            end
            if (ready_o !== 1'b1 || tx_o !== 1'b1 || busy_o !== 1'b0) bad++;
            valid = 1'b1;
            data  = words[i];
        end
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL capture_idle: %0d cycles with wrong ready/tx/busy, required 0", bad);
        end
    endtask

    // Sample the whole block starting on the cycle after the last capture.
    task automatic receive_block(input int n_drops, input bit finish_valid);
        int drop_at [5];
        int wave_bad, busy_bad, done_bad, drop_seen;
        bit inj;
        logic [7:0] b8;
        wave_bad = 0; busy_bad = 0; done_bad = 0; drop_seen = 0;
        for (int d = 0; d < 5; d++) drop_at[d] = 100 + d*300 + int'($urandom_range(50, 0));
        for (int t = 0; t < SPAN; t++) begin
            @(negedge clk);
            line[t] = tx_o;
            if (tx_o !== exp_line(t)) wave_bad++;
            if (busy_o !== 1'b1 || ready_o !== 1'b0) busy_bad++;
            if (done_o !== 1'b0) done_bad++;
            if (drop_o === 1'b1) drop_seen++;
            inj = 1'b0;
            for (int d = 0; d < n_drops; d++) if (drop_at[d] == t) inj = 1'b1;
            valid = inj;
            data  = $urandom;
        end
        checks++;
        if (wave_bad != 0) begin
            failures++;
            $display("FAIL line_wave: %0d cycles differ from expected tx level, required 0", wave_bad);
        end
        checks++;
        if (busy_bad != 0) begin
            failures++;
            $display("FAIL busy_span: %0d cycles with busy!=1 or ready!=0, required 0", busy_bad);
        end
        checks++;
        if (done_bad != 0) begin
            failures++;
            $display("FAIL done_early: done_o high on %0d cycles of the span, required 0", done_bad);
        end
        checks++;
        if (drop_seen != n_drops) begin
            failures++;
            $display("FAIL drop_count: got %0d drop pulses, required %0d", drop_seen, n_drops);
        end
        for (int f = 0; f < NBYTES; f++) begin
            for (int b = 0; b < 8; b++) b8[b] = line[f*FRAME + (b+1)*CPB + CPB/2];
            rx_bytes[f] = b8;
            checks++;
            if (b8 !== exp_bytes[f]) begin
                failures++;
                $display("FAIL rx_byte[%0d]: got %02h, required %02h", f, b8, exp_bytes[f]);
            end
        end
        // Cycle SPAN after the first start bit: the done pulse.
        @(negedge clk);
        checks++;
        if (done_o !== 1'b1 || busy_o !== 1'b0 || tx_o !== 1'b1 || ready_o !== 1'b0) begin
            failures++;
            $display("FAIL finish_outputs: done=%b busy=%b tx=%b ready=%b, required 1 0 1 0",
                     done_o, busy_o, tx_o, ready_o);
        end
        valid = finish_valid;
        data  = $urandom;
        @(negedge clk);
        checks++;
        if (done_o !== 1'b0 || ready_o !== 1'b1) begin
            failures++;
            $display("FAIL after_finish: done=%b ready=%b, required 0 1", done_o, ready_o);
        end
        checks++;
        if (drop_o !== finish_valid) begin
            failures++;
            $display("FAIL finish_drop: drop=%b, required %b", drop_o, finish_valid);
        end
        valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks++;
            if (tx_o !== 1'b1 || ready_o !== 1'b1 || busy_o !== 1'b0 ||
                done_o !== 1'b0 || drop_o !== 1'b0) begin
                failures++;
                $display("FAIL reset_outputs[%0d]: tx=%b ready=%b busy=%b done=%b drop=%b, required 1 1 0 0 0",
                         c, tx_o, ready_o, busy_o, done_o, drop_o);
            end
            valid = ~valid;
            data  = $urandom;
        end
        valid = 1'b0;
        rst_n = 1'b1;
    endtask

    task automatic test_framing();
        logic [7:0] first8 [8];
        logic [9:0] frame0;
        int bad;
        first8 = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hA5, 8'hA5, 8'hA5, 8'hA5};
        frame0 = 10'b10_1111_0000;  // bit 0 is the start bit
        random_words();
        words[0] = 32'h12345678;
        words[1] = 32'hA5A5A5A5;
        build_model();
        send_block(0, 1'b0);
        receive_block(0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (rx_bytes[i] !== first8[i]) begin
                failures++;
                $display("FAIL framing_byte[%0d]: got %02h, required %02h", i, rx_bytes[i], first8[i]);
            end
        end
        bad = 0;
        for (int t = 0; t < FRAME; t++) if (line[t] !== frame0[t / CPB]) bad++;
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL frame0_shape: %0d cycles differ, required 0", bad);
        end
    endtask

    task automatic test_full_block(input int max_gap);
        logic [7:0] e;
        for (int i = 0; i < RADIX; i++) words[i] = W'(i);
        build_model();
        send_block(max_gap, 1'b0);
        receive_block(0, 1'b0);
        for (int i = 0; i < NBYTES; i += 4) begin
            e = 8'(i / 4);
            checks++;
            if (rx_bytes[i] !== e || rx_bytes[i+1] !== 8'h00 ||
                rx_bytes[i+2] !== 8'h00 || rx_bytes[i+3] !== 8'h00) begin
                failures++;
                $display("FAIL index_word[%0d]: got %02h %02h %02h %02h, required %02h 00 00 00",
                         i/4, rx_bytes[i], rx_bytes[i+1], rx_bytes[i+2], rx_bytes[i+3], e);
            end
        end
    endtask

    task automatic test_drop_back_to_back();
        random_words();
        build_model();
        send_block(2, 1'b0);
        receive_block(5, 1'b1);
        random_words();
        build_model();
        // Previous block leaves us on the cycle after FINISH: capture word 0 now.
        send_block(0, 1'b1);
        receive_block(0, 1'b0);
    endtask

    task automatic test_reset_mid_frame();
        random_words();
        build_model();
        send_block(0, 1'b0);
        // Stop inside the data bits of byte 3.
        for (int t = 0; t < int'(3*FRAME + 4*CPB + 1); t++) begin
            @(negedge clk);
            valid = 1'b0;
        end
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if (tx_o !== 1'b1 || busy_o !== 1'b0 || ready_o !== 1'b1 || done_o !== 1'b0) begin
            failures++;
            $display("FAIL midframe_reset: tx=%b busy=%b ready=%b done=%b, required 1 0 1 0",
                     tx_o, busy_o, ready_o, done_o);
        end
        rst_n = 1'b1;
        random_words();
        build_model();
        send_block(1, 1'b0);
        receive_block(0, 1'b0);
    endtask

    initial begin
        valid = 1'b0;
        data  = '0;
        rst_n = 1'b0;
        test_reset();
        test_framing();
        test_full_block(0);
        test_full_block(5);
        test_drop_back_to_back();
        test_reset_mid_frame();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ntt_result_uart_writer.md
Name: ntt_result_uart_writer

Overview:
Return path of the NTT accelerator. Captures one block of RADIX results streamed out of the NTT core. Serializes each W-bit result onto the UART line as W/8 bytes, least-significant byte first, in 8N1 format. It is the transmit counterpart of the uart_rx/uart_reader input path, so the PC receives results in the same byte order it used to send data.

Parameters:
W, 32, result word width; must be a multiple of 8
RADIX, 16, number of result words per block
CLKS_PER_BIT, 87, clock cycles per UART bit; must be >= 2
BYTES_PER_WORD, W/8, derived; bytes sent per word

Ports:
clk_i  input  1  clock; all logic on rising edge
rst_n_i  input  1  synchronous active-low reset
result_valid_i  input  1  result_data_i holds a valid result this cycle
result_data_i  input  W  NTT result word
ready_o  output  1  block is accepting results (CAPTURE state)
tx_o  output  1  UART serial line, idle high
busy_o  output  1  transmission of the current block in progress
done_o  output  1  one-cycle pulse when the last stop bit of the block has completed
drop_o  output  1  one-cycle pulse when result_valid_i arrives while ready_o is low

Behaviour:
- Reset (rst_n_i low at a clock edge), regardless of current state:
  - state <= CAPTURE, word count 0, byte index 0, bit index 0, baud counter 0.
  - tx_o=1, ready_o=1, busy_o=0, done_o=0, drop_o=0.
  - A frame in progress is abandoned; tx_o is high from the next edge.
- Storage: buffer of RADIX x W registers; word counter $clog2(RADIX)+1 bits.
- CAPTURE:
  - Each cycle with result_valid_i=1, store result_data_i at buffer[count] and increment count.
  - Exactly one word is accepted per valid cycle; no backpressure.
  - When the word at index RADIX-1 is stored, go to START at the next edge with byte pointer = word 0, byte 0.
- START: tx_o=0 for exactly CLKS_PER_BIT cycles.
  - The first start bit begins on the cycle after the last word is captured.
  - busy_o rises on that same cycle.
- DATA: 8 bits, LSB first, each held exactly CLKS_PER_BIT cycles.
  - Byte k of word j is buffer[j][8k+7:8k].
- STOP: tx_o=1 for exactly CLKS_PER_BIT cycles. Then:
  - If more bytes remain: go straight to START for the next byte (k+1, or word j+1 byte 0), with no idle gap.
  - Otherwise go to FINISH.
- FINISH (one cycle): done_o=1, busy_o=0, tx_o=1. Word count is cleared and the next state is CAPTURE.
- Timing and output rules:
  - Frame length is exactly 10*CLKS_PER_BIT cycles.
  - Total time from the first start bit to done_o is RADIX*BYTES_PER_WORD*10*CLKS_PER_BIT cycles; done_o is asserted on the cycle after that span ends.
  - ready_o is high only in CAPTURE; busy_o is high in START/DATA/STOP.
  - Baud counter counts 0..CLKS_PER_BIT-1 and wraps on each bit boundary.
  - tx_o is registered, with no combinational path from any input.
- Drops:
  - result_valid_i=1 in any state other than CAPTURE asserts drop_o on the next cycle; the data is discarded.
  - The buffer is not modified during transmission.
- Simultaneous events:
  - result_valid_i on the FINISH cycle is dropped (drop_o pulses).
  - A valid on the cycle after FINISH is captured as word 0.
- Buffer contents after reset are don't-care; they are never transmitted before being overwritten.

Test Plan:
- Reset check: hold rst_n_i low 3 cycles with result_valid_i toggling -> tx_o=1, ready_o=1, busy_o=0, done_o=0, drop_o=0 on every cycle. Release reset -> no tx_o activity until 16 words have been captured.
- Single-word framing (RADIX=2, CLKS_PER_BIT=4):
  - Stimulus: capture 0x12345678 then 0xA5A5A5A5.
  - tx_o bytes are 78,56,34,12,A5,A5,A5,A5. The first frame is 0,0,0,0,1,1,1,1,0,1 with each bit exactly 4 cycles.
  - done_o pulses exactly 320 cycles after the first start bit begins.
- Full block (defaults except CLKS_PER_BIT=4): capture words 0..15 with value = index.
  - A bench UART receiver decodes 64 bytes: 00,00,00,00,01,00,00,00,...,0F,00,00,00.
  - done_o is a single pulse, then ready_o=1.
- Gapped capture: 16 valids spread with random idle cycles -> same byte stream as the back-to-back case; first start bit exactly one cycle after the 16th valid.
- Drop and back-to-back blocks:
  - Assert result_valid_i 5 times during transmission -> 5 drop_o pulses and an unchanged byte stream.
  - A second 16-word block sent after done_o transmits correctly.
- Reset mid-frame: drop rst_n_i during the DATA bits of byte 3 -> tx_o=1 next cycle, busy_o=0. A fresh block afterwards transmits from word 0 byte 0.
